// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    function automatic logic is_signed_a(logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide on a shared
// 2*DATA_W accumulator, one add/sub per step.
module muldiv_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  step,
    input  logic                  div_mode,
    input  logic [DATA_W-1:0]     mag_a,
    input  logic [DATA_W-1:0]     mag_b,
    output logic [2*DATA_W-1:0]   product,
    output logic [DATA_W-1:0]     quotient,
    output logic [DATA_W-1:0]     remainder
);

    logic                  div_q;
    logic [DATA_W-1:0]     m_q;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     addend;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_diff;

    // Multiply: acc = {partial, multiplier}, shifted right. Divide: acc = {rem, dividend/quotient},
    // shifted left with the quotient bit entering at the bottom.
    always_comb begin
        addend   = acc_q[0] ? m_q : {DATA_W{1'b0}};
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, addend};
        div_diff = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {1'b0, m_q};
        acc_d    = acc_q;
        if (init) begin
            acc_d = {{DATA_W{1'b0}}, (div_mode ? mag_a : mag_b)};
        end else if (step) begin
            if (div_q) begin
                if (div_diff[DATA_W]) begin
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end else begin
                    acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end
            end else begin
                acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
            m_q   <= '0;
            acc_q <= '0;
        end else begin
            if (init) begin
                div_q <= div_mode;
                m_q   <= div_mode ? mag_b : mag_a;
            end
            acc_q <= acc_d;
        end
    end

    assign product   = acc_q;
    assign quotient  = acc_q[DATA_W-1:0];
    assign remainder = acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: FSM, iteration counter, sign/special-case fixup and
// result register around the iterative magnitude core.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q;
    logic                sign_a_q, sign_b_q, b_zero_q;
    logic [DATA_W-1:0]   orig_a_q, result_q;
    logic                init, step, load;
    logic                sa, sb;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] product, prod_s;
    logic [DATA_W-1:0]   quotient, remainder, quot_s, rem_s, fix_val;

    always_comb begin
        sa    = is_signed_a(funct3) && op_a[DATA_W-1];
        sb    = is_signed_b(funct3) && op_b[DATA_W-1];
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;
    end

    muldiv_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .step      (step),
        .div_mode  (is_div(funct3)),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init    = 1'b0;
        step    = 1'b0;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    init    = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = StFix;
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    load    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Divide-by-zero overrides; signed overflow falls out of the magnitude path naturally.
    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? -product : product;
        quot_s = (sign_a_q ^ sign_b_q) ? -quotient : quotient;
        rem_s  = sign_a_q ? -remainder : remainder;
        case (op_q)
            OP_MUL:                       fix_val = prod_s[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:              fix_val = b_zero_q ? {DATA_W{1'b1}} : quot_s;
            OP_REM, OP_REMU:              fix_val = b_zero_q ? orig_a_q : rem_s;
            default:                      fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            orig_a_q <= '0;
            result_q <= '0;
        end else begin
            if (init) begin
                op_q     <= funct3;
                sign_a_q <= sa;
                sign_b_q <= sb;
                b_zero_q <= (op_b == '0);
                orig_a_q <= op_a;
            end
            if (load) result_q <= fix_val;
        end
    end

    assign busy   = (state_q == StRun) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: ops, special cases, latency, flush, reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .DATA_W (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one op, optionally pulse start again mid-run, then check result, latency,
    // busy length, single-cycle done, and that no second done follows.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
        int lat;
        int bcnt;
        int extra;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            start = (lat == pulse_at);
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, 32'(lat), 32'd34);
        check({tag, " busy_cycles"}, 32'(bcnt), 32'd33);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check({tag, " extra_done"}, 32'(extra), 32'd0);
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 0);
        run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("DIVU 100/7",     3'b101, 32'd100,        32'd7,         32'd14,        0);
        run_op("REMU 100/7",     3'b111, 32'd100,        32'd7,         32'd2,         0);
        run_op("DIVU x/0",       3'b101, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 0);
        run_op("REM x/0",        3'b110, 32'h8000_1234,  32'd0,         32'h8000_1234, 0);
        run_op("DIV ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("REM ovf",        3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("DIVU 100/7 pulse", 3'b101, 32'd100,      32'd7,         32'd14,        5);

        // Flush in RUN: abort, no done, prior result kept.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, 32'd14);
        @(posedge clk);
        #1;
        check("flush idle done", 32'(done), 32'd0);
        run_op("REMU after flush", 3'b111, 32'd100, 32'd7, 32'd2, 0);

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle flush busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("idle flush busy2", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN, between edges.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_op("MUL 3*5", 3'b000, 32'd3, 32'd5, 32'd15, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
